spi_xfer_engine: RTL and testbench
==================================

SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, giving the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a transaction request, sampled only while idle.
REQ-005 SHALL have port inst, input, 8, the instruction byte (0x0B read, 0x0A write), latched at start.
REQ-006 SHALL have port addr, input, 8, the register address byte, latched at start.
REQ-007 SHALL have port wdata, input, 8, the first data byte to send, latched at start.
REQ-008 SHALL have port nbytes, input, 3, the data byte count N (0 treated as 1), latched at start.
REQ-009 SHALL have port miso, input, 1, serial data from the accelerometer.
REQ-010 SHALL have port sclk, output, 1, the SPI clock (mode 0, idle low).
REQ-011 SHALL have port mosi, output, 1, serial data to the accelerometer, MSB first.
REQ-012 SHALL have port transmit, output, 1, a one-cycle pulse that makes the downstream chip-select drive cs low.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse that makes the downstream chip-select drive cs high.
REQ-014 SHALL have port busy, output, 1, high while a transaction is in progress.
REQ-015 SHALL have port rx_data, output, 8, the last received data byte.
REQ-016 SHALL have port rx_valid, output, 1, a one-cycle strobe marking a new rx_data.

Function
REQ-017 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD and FINISH.
REQ-018 SHALL, in IDLE with start=1 at clk edge E0, latch the inputs, pulse transmit for the one cycle following E0, set busy=1 and move to SETUP.
REQ-019 SHALL drive mosi with inst bit 7 from E0 onward.
REQ-020 SHALL stay in SETUP for CLK_DIV cycles with sclk=0.
REQ-021 SHALL, in SHIFT, shift 8*(2+N) bits in the order inst, addr, wdata, then 0x00 for each further data byte.
REQ-022 SHALL give each bit period 2*CLK_DIV cycles: sclk low for CLK_DIV, then high for CLK_DIV.
REQ-023 SHALL make the first sclk rise at E0+2*CLK_DIV.
REQ-024 SHALL change mosi only at the edge where sclk falls, plus at E0.
REQ-025 SHALL sample miso at the clk edge where the sclk register goes 0->1.
REQ-026 SHALL discard miso bits received during the inst and addr bytes.
REQ-027 SHALL, after the 8th sample of each data byte, load rx_data and pulse rx_valid for one cycle at the next edge; rx_data holds until the next load.
REQ-028 SHALL, after the last sclk fall, go to HOLD for CLK_DIV cycles with sclk=0.
REQ-029 SHALL then go to FINISH: done=1 for one cycle with busy still 1, then IDLE with busy=0.
REQ-030 SHALL, for N=1 and CLK_DIV=4, assert done at E0+200.
REQ-031 SHALL ignore start while busy=1, and ignore it in the FINISH cycle.
REQ-032 SHALL accept a new start at the first IDLE cycle.
REQ-033 SHALL never assert transmit and done in the same cycle.
REQ-034 SHALL keep the bit counter at 3 bits and the byte counter at 3 bits; the divider counter is wide enough for CLK_DIV-1.
REQ-035 SHALL produce no counter wrap that leaves the SHIFT state early.
REQ-036 SHALL give rx_valid priority over nothing else: it may coincide with the transition into HOLD.

Reset
REQ-037 SHALL, on rst=1 at any time (asynchronous), force state=IDLE, sclk=0, mosi=0, transmit=0, done=0, busy=0, rx_valid=0 and rx_data=0x00, and clear all counters.
REQ-038 SHALL NOT pulse done on a reset during a transaction; the chip-select stage deasserts cs from the same rst.
REQ-039 SHALL leave the block idle on the first clk edge after rst falls, with start sampled normally.

Verification
REQ-040 SHALL cover: CLK_DIV=4, inst=0x0B, addr=0x00, N=1, slave returns 0xAD -> mosi bytes 0x0B,0x00,0x00; 24 sclk rises; one rx_valid with rx_data=0xAD; done at E0+200.
REQ-041 SHALL cover: a burst read with addr=0x0E, N=6, slave returning 0x01..0x06 -> six rx_valid pulses in order 0x01..0x06 and 64 sclk rises.
REQ-042 SHALL cover: a write with inst=0x0A, addr=0x2D, wdata=0x02, N=1 -> mosi bytes 0x0A,0x2D,0x02 and exactly one transmit and one done.
REQ-043 SHALL cover: start held high through a whole transaction -> a second transaction begins only at the first IDLE edge after done, and no overlap of transmit with busy from the prior transaction.
REQ-044 SHALL cover: rst pulsed during bit 10 -> all outputs go to reset values with no clk edge, no done; a following N=1 read completes normally.
REQ-045 SHALL cover: nbytes=0 -> behaves exactly as N=1 (24 bits, one rx_valid).

Source files
------------

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 transfer engine for an accelerometer register interface.
// Sends inst, addr, wdata then 0x00 fill bytes MSB first, and returns each
// received data byte on rx_data with a one-cycle rx_valid strobe.
//
// state  | meaning
// IDLE   | waiting for start; start sampled here only
// SETUP  | cs just asserted, sclk held low for CLK_DIV cycles
// SHIFT  | bit periods of 2*CLK_DIV cycles (low half, then high half)
// HOLD   | sclk low for CLK_DIV cycles after the last falling edge
// FINISH | one-cycle done pulse, busy still high
module spi_xfer_engine #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] inst,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [2:0] nbytes,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       transmit,
    output logic       done,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;     // data bytes still to send after the current one
    logic [1:0]    hdr_q, hdr_d;       // 0: inst byte, 1: addr byte, 2: data bytes
    logic [7:0]    tx_q, tx_d;         // current byte, MSB is the bit on mosi
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          rx_pend_q, rx_pend_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          transmit_q, transmit_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Next-state and output logic; all outputs are registered.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        hdr_d      = hdr_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rx_sr_d    = rx_sr_q;
        rx_pend_d  = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        transmit_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;

        // A completed data byte is published one edge after its 8th sample,
        // independent of where the FSM has moved in the meantime.
        if (rx_pend_q) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    byte_d     = (nbytes == 3'd0) ? 3'd0 : nbytes - 3'd1;
                    hdr_d      = 2'd0;
                    bit_d      = 3'd0;
                    tx_d       = inst;
                    mosi_d     = inst[7];
                    div_d      = DIV_TOP;
                    transmit_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    div_d   = DIV_TOP;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DW'(1);
                end else begin
                    div_d = DIV_TOP;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], miso};
                        if (bit_q == 3'd7 && hdr_q == 2'd2) begin
                            rx_pend_d = 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end else begin
                            bit_d = 3'd0;
                            case (hdr_q)
                                2'd0: begin
                                    hdr_d  = 2'd1;
                                    tx_d   = addr_q;
                                    mosi_d = addr_q[7];
                                end
                                2'd1: begin
                                    hdr_d  = 2'd2;
                                    tx_d   = wdata_q;
                                    mosi_d = wdata_q[7];
                                end
                                default: begin
                                    tx_d   = 8'h00;
                                    mosi_d = 1'b0;
                                    if (byte_q == 3'd0) begin
                                        state_d = HOLD;
                                    end else begin
                                        byte_d = byte_q - 3'd1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            HOLD: begin
                if (div_q == '0) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= 3'd0;
            byte_q     <= 3'd0;
            hdr_q      <= 2'd0;
            tx_q       <= 8'h00;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            rx_pend_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            transmit_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            hdr_q      <= hdr_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_sr_q    <= rx_sr_d;
            rx_pend_q  <= rx_pend_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            transmit_q <= transmit_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign transmit = transmit_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine with CLK_DIV=4 and a behavioural slave.
module tb_spi_xfer_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] inst = 8'h00;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [2:0] nbytes = 3'd0;
    logic       miso;
    logic       sclk, mosi, transmit, done, busy, rx_valid;
    logic [7:0] rx_data;

    int total = 0;
    int bad = 0;

    spi_xfer_engine #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .inst(inst), .addr(addr),
        .wdata(wdata), .nbytes(nbytes), .miso(miso), .sclk(sclk), .mosi(mosi),
        .transmit(transmit), .done(done), .busy(busy), .rx_data(rx_data),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave response: bit k of the frame is resp_bits[71-k], MSB first.
    logic [71:0] resp_bits = '0;
    int rc = 0;
    always_comb begin
        miso = 1'b0;
        if (rc < 72) miso = resp_bits[7'(71 - rc)];
    end

    // Observer on the falling clk edge.
    int tx_cnt = 0, done_cnt = 0, tx_cyc = 0, done_cyc = 0;
    int first_rise_cyc = -1, rx_n = 0, overlap_cnt = 0;
    logic [71:0] mosi_bits = '0;
    logic [7:0]  rx_bytes [0:7];
    logic prev_sclk = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (transmit) begin
            tx_cnt++;
            tx_cyc = cyc;
            rc = 0;
            mosi_bits = '0;
            rx_n = 0;
            first_rise_cyc = -1;
            if (prev_busy || done) overlap_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (sclk && !prev_sclk) begin
            mosi_bits = {mosi_bits[70:0], mosi};
            if (first_rise_cyc < 0) first_rise_cyc = cyc;
            rc++;
        end
        if (rx_valid) begin
            if (rx_n < 8) rx_bytes[rx_n] = rx_data;
            rx_n++;
        end
        prev_sclk = sclk;
        prev_busy = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] i, input logic [7:0] a,
                          input logic [7:0] w, input logic [2:0] n);
        @(negedge clk);
        inst = i; addr = a; wdata = w; nbytes = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got %0b want 0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got %0b want 0", mosi); end
        total++; if (transmit !== 1'b0) begin bad++; $display("FAIL reset_transmit got %0b want 0", transmit); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got %0b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got %0h want 00", rx_data); end
    endtask

    task automatic test_read_single();
        bit ok;
        int d0;
        d0 = done_cnt;
        resp_bits = {16'h0000, 8'hAD, 48'h0};
        launch(8'h0B, 8'h00, 8'h00, 3'd1);
        wait_done(d0, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got no done want done"); end
        total++; if (done_cyc - tx_cyc !== 200) begin bad++; $display("FAIL single_done_time got %0d want 200", done_cyc - tx_cyc); end
        total++; if (first_rise_cyc - tx_cyc !== 8) begin bad++; $display("FAIL single_first_rise got %0d want 8", first_rise_cyc - tx_cyc); end
        total++; if (mosi_bits[23:0] !== 24'h0B0000) begin bad++; $display("FAIL single_mosi got %0h want 0b0000", mosi_bits[23:0]); end
        total++; if (rc !== 24) begin bad++; $display("FAIL single_rises got %0d want 24", rc); end
        total++; if (rx_n !== 1) begin bad++; $display("FAIL single_rx_count got %0d want 1", rx_n); end
        total++; if (rx_bytes[0] !== 8'hAD) begin bad++; $display("FAIL single_rx_data got %0h want ad", rx_bytes[0]); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_at_done got %0b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_width got %0b want 0", done); end
    endtask

    task automatic test_burst();
        bit ok;
        int d0;
        d0 = done_cnt;
        resp_bits = {16'h0000, 48'h010203040506, 8'h00};
        launch(8'h0B, 8'h0E, 8'h00, 3'd6);
        wait_done(d0, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_timeout got no done want done"); end
        total++; if (rc !== 64) begin bad++; $display("FAIL burst_rises got %0d want 64", rc); end
        total++; if (rx_n !== 6) begin bad++; $display("FAIL burst_rx_count got %0d want 6", rx_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rx_bytes[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL burst_rx_byte%0d got %0h want %0h", i, rx_bytes[i], i + 1);
            end
        end
        total++; if (mosi_bits[63:0] !== 64'h0B0E_0000_0000_0000) begin bad++; $display("FAIL burst_mosi got %0h want 0b0e000000000000", mosi_bits[63:0]); end
        total++; if (done_cyc - tx_cyc !== 520) begin bad++; $display("FAIL burst_done_time got %0d want 520", done_cyc - tx_cyc); end
        tick();
    endtask

    task automatic test_write();
        bit ok;
        int d0, t0;
        d0 = done_cnt;
        t0 = tx_cnt;
        resp_bits = '0;
        launch(8'h0A, 8'h2D, 8'h02, 3'd1);
        wait_done(d0, 400, ok);
        repeat (6) tick();
        total++; if (!ok) begin bad++; $display("FAIL write_timeout got no done want done"); end
        total++; if (mosi_bits[23:0] !== 24'h0A2D02) begin bad++; $display("FAIL write_mosi got %0h want 0a2d02", mosi_bits[23:0]); end
        total++; if (tx_cnt - t0 !== 1) begin bad++; $display("FAIL write_transmit_count got %0d want 1", tx_cnt - t0); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL write_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        bit ok, ok2;
        int d0, t0, done1;
        d0 = done_cnt;
        t0 = tx_cnt;
        resp_bits = {16'h0000, 8'h77, 48'h0};
        @(negedge clk);
        inst = 8'h0B; addr = 8'h00; wdata = 8'h00; nbytes = 3'd1;
        start = 1'b1;
        wait_done(d0, 400, ok);
        done1 = done_cyc;
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got no done want done"); end
        ok2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_cnt == t0 + 2) begin
                ok2 = 1'b1;
                break;
            end
        end
        start = 1'b0;
        total++; if (!ok2) begin bad++; $display("FAIL b2b_second_timeout got no transmit want transmit"); end
        total++; if (tx_cyc - done1 !== 2) begin bad++; $display("FAIL b2b_restart_gap got %0d want 2", tx_cyc - done1); end
        wait_done(d0 + 1, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_second_done_timeout got no done want done"); end
        total++; if (done_cyc - tx_cyc !== 200) begin bad++; $display("FAIL b2b_second_time got %0d want 200", done_cyc - tx_cyc); end
        total++; if (rx_bytes[0] !== 8'h77) begin bad++; $display("FAIL b2b_rx_data got %0h want 77", rx_bytes[0]); end
        repeat (4) tick();
        total++; if (tx_cnt - t0 !== 2) begin bad++; $display("FAIL b2b_transmit_count got %0d want 2", tx_cnt - t0); end
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL b2b_overlap got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        d0 = done_cnt;
        resp_bits = '0;
        launch(8'h0B, 8'h20, 8'h00, 3'd1);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rc >= 11) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL mid_reach_bit10 got rc=%0d want 11", rc); end
        total++; if (mosi !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre_reset got mosi=%0b busy=%0b want 1 1", mosi, busy); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL mid_sclk got %0b want 0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL mid_mosi got %0b want 0", mosi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %0b want 0", busy); end
        total++; if (done !== 1'b0 || transmit !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL mid_pulses got %0b%0b%0b want 000", done, transmit, rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data got %0h want 00", rx_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL mid_no_done got %0d want %0d", done_cnt, d0); end
        d0 = done_cnt;
        resp_bits = {16'h0000, 8'h5A, 48'h0};
        launch(8'h0B, 8'h00, 8'h00, 3'd1);
        wait_done(d0, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_after_timeout got no done want done"); end
        total++; if (done_cyc - tx_cyc !== 200) begin bad++; $display("FAIL mid_after_time got %0d want 200", done_cyc - tx_cyc); end
        total++; if (rx_n !== 1 || rx_bytes[0] !== 8'h5A) begin bad++; $display("FAIL mid_after_rx got n=%0d data=%0h want n=1 data=5a", rx_n, rx_bytes[0]); end
        tick();
    endtask

    task automatic test_nbytes_zero();
        bit ok;
        int d0;
        d0 = done_cnt;
        resp_bits = {16'h0000, 8'h3C, 48'h0};
        launch(8'h0B, 8'h11, 8'h00, 3'd0);
        wait_done(d0, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL n0_timeout got no done want done"); end
        total++; if (rc !== 24) begin bad++; $display("FAIL n0_rises got %0d want 24", rc); end
        total++; if (rx_n !== 1) begin bad++; $display("FAIL n0_rx_count got %0d want 1", rx_n); end
        total++; if (rx_bytes[0] !== 8'h3C) begin bad++; $display("FAIL n0_rx_data got %0h want 3c", rx_bytes[0]); end
        total++; if (mosi_bits[23:0] !== 24'h0B1100) begin bad++; $display("FAIL n0_mosi got %0h want 0b1100", mosi_bits[23:0]); end
        total++; if (done_cyc - tx_cyc !== 200) begin bad++; $display("FAIL n0_done_time got %0d want 200", done_cyc - tx_cyc); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_single();
        test_burst();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_nbytes_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
